// File: rtl/nios2_oci_pkg.sv
// Purpose: shared types and jdo field offsets for the OCI RAM arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nios2_oci_pkg;

    localparam int JDO_W     = 38;
    localparam int ADDR_LSB  = 17;
    localparam int WDATA_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AV_WR   = 3'd1,
        ST_AV_RD   = 3'd2,
        ST_AV_DATA = 3'd3,
        ST_JT_WR   = 3'd4,
        ST_JT_RD   = 3'd5,
        ST_JT_DATA = 3'd6
    } arb_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

    typedef enum logic {
        GNT_AV = 1'b0,
        GNT_JT = 1'b1
    } grant_e;

endpackage

// File: rtl/nios2_oci_jtag_req.sv
// Purpose: latch one JTAG RAM request from the take_action strobes; own the JTAG address counter.
// Latency: strobe -> pending flag (or jaddr load) in 1 cycle.
// Backpressure: none upstream; strobes arriving while busy are dropped and flagged in overrun.
module nios2_oci_jtag_req
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              in_service,
    input  logic              req_take,
    input  logic              jaddr_inc,
    output logic              req_pend,
    output req_kind_e         req_kind,
    output logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] jaddr,
    output logic              overrun
);

    logic              pend_q, pend_d;
    req_kind_e         kind_q, kind_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic              overrun_q, overrun_d;
    logic              blocked;
    logic              any_strobe;
    logic              unused_jdo_bits;

    // Only the address and write-data fields of jdo are meaningful here.
    assign unused_jdo_bits = ^{jdo[JDO_W-1:WDATA_LSB+DATA_W], jdo[WDATA_LSB-1:0]};

    // Strobe priority a > b > no_action; losers and strobes hitting a busy request only raise overrun.
    always_comb begin
        pend_d     = pend_q;
        kind_d     = kind_q;
        wdata_d    = wdata_q;
        jaddr_d    = jaddr_q;
        overrun_d  = overrun_q;
        blocked    = pend_q | in_service;
        any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

        if (req_take) begin
            pend_d = 1'b0;
        end
        if (jaddr_inc) begin
            jaddr_d = jaddr_q + 1'b1;
        end

        if (blocked) begin
            if (any_strobe) begin
                overrun_d = 1'b1;
            end
        end else if (take_action_ocimem_a) begin
            jaddr_d = jdo[ADDR_LSB +: ADDR_W];
            if (take_action_ocimem_b | take_no_action_ocimem_a) begin
                overrun_d = 1'b1;
            end
        end else if (take_action_ocimem_b) begin
            pend_d  = 1'b1;
            kind_d  = REQ_WR;
            wdata_d = jdo[WDATA_LSB +: DATA_W];
            if (take_no_action_ocimem_a) begin
                overrun_d = 1'b1;
            end
        end else if (take_no_action_ocimem_a) begin
            pend_d = 1'b1;
            kind_d = REQ_RD;
        end
    end

    // Request state registers; a reset discards any pending request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= 1'b0;
            kind_q    <= REQ_RD;
            wdata_q   <= '0;
            jaddr_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            kind_q    <= kind_d;
            wdata_q   <= wdata_d;
            jaddr_q   <= jaddr_d;
            overrun_q <= overrun_d;
        end
    end

    assign req_pend  = pend_q;
    assign req_kind  = kind_q;
    assign req_wdata = wdata_q;
    assign jaddr     = jaddr_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/nios2_oci_ram_arbiter.sv
// Purpose: share the single-port OCI RAM between the JTAG debug path and the Avalon debug slave.
// Latency: Avalon write 1 wait cycle, Avalon read 2 wait cycles; JTAG read data in MonDReg 4 cycles after strobe.
// Backpressure: Avalon stalled via av_waitrequest; JTAG strobes dropped (jtag_overrun) while a request is busy.
module nios2_oci_ram_arbiter
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;

    logic              req_pend;
    req_kind_e         req_kind;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] jaddr;
    logic              jtag_overrun_w;
    logic              req_take;
    logic              jaddr_inc;
    logic              jt_in_service;
    logic              av_req;
    logic              jt_win;

    assign jt_in_service = (state_q == ST_JT_WR) || (state_q == ST_JT_RD) || (state_q == ST_JT_DATA);
    assign jaddr_inc     = (state_q == ST_JT_WR) || (state_q == ST_JT_DATA);

    nios2_oci_jtag_req #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_req (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .in_service              (jt_in_service),
        .req_take                (req_take),
        .jaddr_inc               (jaddr_inc),
        .req_pend                (req_pend),
        .req_kind                (req_kind),
        .req_wdata               (req_wdata),
        .jaddr                   (jaddr),
        .overrun                 (jtag_overrun_w)
    );

    // Arbitration and sequencing; on a tie the requester not served last wins.
    // RAM address/data are captured on entry to an issue state and held otherwise.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        req_take     = 1'b0;
        av_req       = av_read | av_write;
        jt_win       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                jt_win = req_pend && (!av_req || (last_grant_q == GNT_AV));
                if (jt_win) begin
                    req_take     = 1'b1;
                    last_grant_d = GNT_JT;
                    ram_addr_d   = jaddr;
                    if (req_kind == REQ_WR) begin
                        state_d     = ST_JT_WR;
                        ram_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_JT_RD;
                    end
                end else if (av_req) begin
                    last_grant_d = GNT_AV;
                    ram_addr_d   = av_address;
                    // read+write together is treated as a write
                    if (av_write) begin
                        state_d     = ST_AV_WR;
                        ram_wdata_d = av_writedata;
                    end else begin
                        state_d = ST_AV_RD;
                    end
                end
            end
            ST_AV_RD: state_d = ST_AV_DATA;
            ST_JT_RD: state_d = ST_JT_DATA;
            default:  state_d = ST_IDLE;
        endcase
    end

    // JTAG read data is captured in the cycle the RAM returns it.
    always_comb begin
        mon_dreg_d = mon_dreg_q;
        if (state_q == ST_JT_DATA) begin
            mon_dreg_d = ram_rdata;
        end
    end

    // Arbiter state registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_AV;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            mon_dreg_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            mon_dreg_q   <= mon_dreg_d;
        end
    end

    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_wren       = (state_q == ST_AV_WR) || (state_q == ST_JT_WR);
    assign av_waitrequest = !((state_q == ST_AV_WR) || (state_q == ST_AV_DATA));
    assign av_readdata    = (state_q == ST_AV_DATA) ? ram_rdata : '0;
    assign MonDReg        = mon_dreg_q;
    assign jtag_busy      = req_pend | jt_in_service;
    assign jtag_overrun   = jtag_overrun_w;

endmodule

// File: tb/tb_nios2_oci_ram_arbiter.sv
// Purpose: directed self-checking bench for nios2_oci_ram_arbiter with a behavioural 1-cycle RAM.
// Latency: checks cycle-exact Avalon wait counts and JTAG strobe-to-data timing.
// Backpressure: Avalon master holds its request while av_waitrequest is high.
module tb_nios2_oci_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [256];
    logic        mem_clr = 1'b1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;      // write data, or expected read data
        int          exp_waits;
    } av_vec_t;

    av_vec_t vecs [8];

    always #5 clk = ~clk;

    nios2_oci_ram_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic strobe_a(input logic [7:0] a);
        @(posedge clk); #1;
        jdo = jdo_addr(a);
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // JTAG write with cycle checks: strobe in T, JT_WR in T+2, jaddr+1 and busy low in T+3.
    task automatic jtag_write(input logic [31:0] d, input logic [7:0] exp_addr);
        logic [7:0] nxt;
        nxt = exp_addr + 8'd1;
        @(posedge clk); #1;
        jdo = jdo_data(d);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        check("jwr_busy_t1", jtag_busy, 1);
        @(negedge clk);
        check("jwr_wren_t2", ram_wren, 1);
        check("jwr_addr_t2", ram_addr, exp_addr);
        check("jwr_wdata_t2", ram_wdata, d);
        @(negedge clk);
        check("jwr_jaddr_t3", dut.jaddr, nxt);
        check("jwr_busy_t3", jtag_busy, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic av_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int waits, output int lows);
        logic done;
        @(posedge clk); #1;
        av_address   = a;
        av_writedata = d;
        av_write     = wr;
        av_read      = !wr;
        waits = 0;
        rd    = '0;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!av_waitrequest) begin
                done = 1'b1;
                rd   = av_readdata;
            end else begin
                waits++;
            end
        end
        if (!done) waits = -1;
        @(posedge clk); #1;
        av_read  = 1'b0;
        av_write = 1'b0;
        @(negedge clk);
        lows = int'(done) + int'(!av_waitrequest);
    endtask

    initial begin
        logic [31:0] rd;
        int          waits;
        int          lows;
        int          exp_trace [10];
        int          code;

        vecs[0] = '{wr: 1'b1, addr: 8'h10, data: 32'hDEADBEEF, exp_waits: 1};
        vecs[1] = '{wr: 1'b0, addr: 8'h10, data: 32'hDEADBEEF, exp_waits: 2};
        vecs[2] = '{wr: 1'b1, addr: 8'h20, data: 32'h00000001, exp_waits: 1};
        vecs[3] = '{wr: 1'b0, addr: 8'h20, data: 32'h00000001, exp_waits: 2};
        vecs[4] = '{wr: 1'b0, addr: 8'hFE, data: 32'hA5A5A5A5, exp_waits: 2};
        vecs[5] = '{wr: 1'b0, addr: 8'hFF, data: 32'h12345678, exp_waits: 2};
        vecs[6] = '{wr: 1'b1, addr: 8'hFF, data: 32'hCAFEF00D, exp_waits: 1};
        vecs[7] = '{wr: 1'b0, addr: 8'hFF, data: 32'hCAFEF00D, exp_waits: 2};

        // 1 = JTAG write in service, 2 = Avalon read data phase, 0 = neither
        exp_trace = '{0, 1, 0, 0, 2, 0, 1, 0, 0, 2};

        // Reset values
        @(negedge clk);
        check("rst_waitreq", av_waitrequest, 1);
        check("rst_readdata", av_readdata, 0);
        check("rst_mondreg", MonDReg, 0);
        check("rst_busy", jtag_busy, 0);
        check("rst_overrun", jtag_overrun, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_ramaddr", ram_addr, 0);
        check("rst_ramwdata", ram_wdata, 0);
        @(negedge clk);
        mem_clr = 1'b0;
        reset_n = 1'b1;

        // JTAG burst across the top of the address space
        strobe_a(8'hFE);
        check("burst_jaddr_load", dut.jaddr, 8'hFE);
        repeat (4) @(negedge clk);
        jtag_write(32'hA5A5A5A5, 8'hFE);
        jtag_write(32'h12345678, 8'hFF);
        check("burst_mem_fe", mem[8'hFE], 32'hA5A5A5A5);
        check("burst_mem_ff", mem[8'hFF], 32'h12345678);
        check("burst_jaddr_wrap", dut.jaddr, 8'h00);

        // JTAG readback: MonDReg updates exactly 4 cycles after the strobe
        strobe_a(8'hFE);
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("jrd_busy_t1", jtag_busy, 1);
        @(negedge clk);
        check("jrd_addr_t2", ram_addr, 8'hFE);
        @(negedge clk);
        check("jrd_mondreg_t3", MonDReg, 32'h0);
        @(negedge clk);
        check("jrd_mondreg_t4", MonDReg, 32'hA5A5A5A5);
        check("jrd_busy_t4", jtag_busy, 0);
        check("jrd_jaddr", dut.jaddr, 8'hFF);

        // Avalon vector table
        for (int i = 0; i < 8; i++) begin
            av_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, waits, lows);
            check($sformatf("av_waits[%0d]", i), waits, vecs[i].exp_waits);
            check($sformatf("av_lowcycles[%0d]", i), lows, 1);
            if (vecs[i].wr)
                check($sformatf("av_memwr[%0d]", i), mem[vecs[i].addr], vecs[i].data);
            else
                check($sformatf("av_rdata[%0d]", i), rd, vecs[i].data);
        end

        // Reset asserted while in AV_RD
        @(posedge clk); #1;
        av_address = 8'h10;
        av_read    = 1'b1;
        @(posedge clk); #1;
        check("midrd_addr", ram_addr, 8'h10);
        check("midrd_waitreq", av_waitrequest, 1);
        reset_n = 1'b0;
        #1;
        check("midrd_rst_waitreq", av_waitrequest, 1);
        check("midrd_rst_readdata", av_readdata, 0);
        check("midrd_rst_mondreg", MonDReg, 0);
        check("midrd_rst_ramaddr", ram_addr, 0);
        check("midrd_rst_ramwdata", ram_wdata, 0);
        check("midrd_rst_wren", ram_wren, 0);
        check("midrd_rst_jaddr", dut.jaddr, 0);
        av_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        av_xfer(1'b0, 8'h10, 32'h0, rd, waits, lows);
        check("postrst_waits", waits, 2);
        check("postrst_rdata", rd, 32'hDEADBEEF);

        // Tie alternation: JTAG write pending against a continuously held Avalon read
        do_reset();
        @(posedge clk); #1;
        jdo = jdo_data(32'h0000AAAA);
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        av_address = 8'h40;
        av_read    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                @(posedge clk); #1;
                jdo = jdo_data(32'h0000BBBB);
                take_action_ocimem_b = 1'b1;
            end
            if (k == 3) begin
                @(posedge clk); #1;
                take_action_ocimem_b = 1'b0;
            end
            @(negedge clk);
            code = ram_wren ? 1 : (!av_waitrequest ? 2 : 0);
            check($sformatf("tie_trace[%0d]", k + 1), code, exp_trace[k]);
        end
        @(posedge clk); #1;
        av_read = 1'b0;
        repeat (3) @(negedge clk);
        check("tie_mem0", mem[8'h00], 32'h0000AAAA);
        check("tie_mem1", mem[8'h01], 32'h0000BBBB);
        check("tie_no_overrun", jtag_overrun, 0);

        // Overrun: a second write strobe one cycle after the first is dropped
        @(posedge clk); #1;
        jdo = jdo_data(32'h11111111);
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        jdo = jdo_data(32'h22222222);
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        repeat (6) @(negedge clk);
        check("ovr_flag", jtag_overrun, 1);
        check("ovr_mem2", mem[8'h02], 32'h11111111);
        check("ovr_mem3", mem[8'h03], 32'h0);
        check("ovr_jaddr", dut.jaddr, 8'h03);
        repeat (5) @(negedge clk);
        check("ovr_sticky", jtag_overrun, 1);

        // Simultaneous strobes: address load wins, the others only flag overrun
        do_reset();
        check("sim_overrun_clr", jtag_overrun, 0);
        @(posedge clk); #1;
        jdo = jdo_addr(8'h33);
        take_action_ocimem_a    = 1'b1;
        take_action_ocimem_b    = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("sim_jaddr", dut.jaddr, 8'h33);
        check("sim_busy", jtag_busy, 0);
        check("sim_overrun", jtag_overrun, 1);
        repeat (4) @(negedge clk);
        check("sim_no_write", mem[8'h33], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nios2_oci_ram_arbiter.md
# nios2_oci_ram_arbiter

Shares the single-port on-chip debug (OCI) RAM between two requesters: the JTAG debug path and the CPU's Avalon debug slave. The JTAG path arrives as one-cycle `take_action_*` strobes with `jdo` payload on the system clock. The Avalon slave is stallable. The block latches JTAG requests, arbitrates fairly, sequences RAM read/write cycles, and returns JTAG read data in `MonDReg`.

## Interface
Parameters:
- `ADDR_W`, 8: OCI RAM address width; the RAM has 2^ADDR_W words.
- `DATA_W`, 32: RAM word width; fixed at 32 because of the `jdo` packing.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  JTAG payload. Address is `jdo[17+ADDR_W-1:17]`. Write data is `jdo[34:3]`.
- `take_action_ocimem_a`  in  1  strobe: load JTAG address register from `jdo`.
- `take_action_ocimem_b`  in  1  strobe: write `jdo[34:3]` at the JTAG address, then increment the address.
- `take_no_action_ocimem_a`  in  1  strobe: read at the JTAG address into `MonDReg`, then increment the address.
- `MonDReg`  out  32  last JTAG read data.
- `jtag_busy`  out  1  a JTAG request is pending or in service.
- `jtag_overrun`  out  1  sticky flag: a strobe was dropped. Cleared only by reset.
- `av_address`  in  ADDR_W; `av_read`, `av_write`  in  1; `av_writedata`  in  32.
- `av_readdata`  out  32; `av_waitrequest`  out  1.
- `ram_addr`  out  ADDR_W; `ram_wren`  out  1; `ram_wdata`  out  32; `ram_rdata`  in  32 (RAM has 1-cycle read latency).

## Operation
- **JTAG request latch:**
  - `ocimem_b` and `no_action_ocimem_a` set a pending flag with kind WR or RD. WR also captures the write data.
  - `ocimem_a` loads `jaddr` immediately.
  - Any strobe arriving while a request is pending or in service is dropped and sets `jtag_overrun`. Dropped strobes leave `jaddr` unchanged.
  - If strobes are simultaneous, priority is `ocimem_a` > `ocimem_b` > `no_action_ocimem_a`. Only the winner acts; the rest set overrun.
- **FSM states:** IDLE, AV_WR, AV_RD, AV_DATA, JT_WR, JT_RD, JT_DATA.
- **Arbitration in IDLE:**
  - Candidates are a pending JTAG request and Avalon `av_read|av_write`.
  - If both are present, grant the requester not granted last (`last_grant` bit; reset value = Avalon, so JTAG wins the first tie).
  - `av_write` and `av_read` together is illegal; treat it as a write.
- **Transitions:**
  - AV_WR → IDLE.
  - AV_RD → AV_DATA → IDLE.
  - JT_WR → IDLE.
  - JT_RD → JT_DATA → IDLE.
- **RAM drive:**
  - `ram_addr`/`ram_wdata` are driven from the granted source in the AV_* / JT_* issue states.
  - `ram_wren` = 1 only in AV_WR and JT_WR.
  - `ram_addr` holds its value in IDLE.
- **Address increment:** `jaddr` increments on JT_WR and JT_DATA exit, modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0).
- **`MonDReg`:** loaded from `ram_rdata` in JT_DATA.
- **Reset values:**
  - state IDLE
  - `MonDReg` 0
  - `jaddr` 0
  - pending 0
  - `jtag_busy` 0
  - `jtag_overrun` 0
  - `av_waitrequest` 1
  - `av_readdata` 0
  - `ram_wren` 0
  - `ram_addr` 0
  - `ram_wdata` 0
- **Reset mid-operation:** the transaction is abandoned, nothing is retried, and the pending request is lost.

## Timing
- **Avalon write** requested at T (IDLE, granted): AV_WR at T+1 with `ram_wren`=1 and `av_waitrequest`=0. This gives one wait cycle.
- **Avalon read** at T: AV_RD at T+1; AV_DATA at T+2 with `av_waitrequest`=0 and `av_readdata`=`ram_rdata`. This gives two wait cycles.
- **`av_waitrequest`** is 1 in every cycle except AV_WR and AV_DATA. The master holds its request stable while stalled.
- **JTAG write** strobe at T: pending at T+1. If granted at T+1, JT_WR at T+2 and `jaddr`+1 visible at T+3.
- **JTAG read** strobe at T: JT_RD at T+2; JT_DATA at T+3; `MonDReg` valid at T+4.
- **`jtag_busy`** rises the cycle after the strobe and falls the cycle after the final state.
- **Worst-case JTAG wait** is one full Avalon read (3 cycles) because of alternation.

## Structure
- Package `nios2_oci_pkg` holds:
  - the FSM state enum
  - the `jdo` field offsets (ADDR_LSB=17, WDATA_LSB=3)
  - the request kind enum (RD/WR).
- Sub-module `nios2_oci_jtag_req` contains the strobe priority, pending flag, write-data capture, `jaddr` counter and overrun flag. The arbiter FSM stays in the top module.

## Test plan
- **JTAG burst:** `ocimem_a` with address 0xFE, then two `ocimem_b` with 0xA5A5A5A5 and 0x12345678, spaced 8 cycles apart → RAM[0xFE]=0xA5A5A5A5, RAM[0xFF]=0x12345678, `jaddr`=0x00 (wrap).
- **JTAG readback:** `ocimem_a` 0xFE, then `no_action_ocimem_a` → `MonDReg`=0xA5A5A5A5 exactly 4 cycles after the strobe; `jaddr`=0xFF.
- **Avalon timing:** write 0xDEADBEEF to address 0x10, then read 0x10 → `av_waitrequest` low for exactly 1 cycle (write, 1 wait cycle) and 1 cycle (read, after 2 wait cycles); `av_readdata`=0xDEADBEEF.
- **Tie alternation:** JTAG write pending while an Avalon read is held continuously → grant order JTAG, Avalon, JTAG…; after reset the first tie goes to JTAG.
- **Overrun:** second `ocimem_b` one cycle after the first → only the first write lands, `jtag_overrun`=1 (sticky), `jaddr` advanced by 1.
- **Reset mid-read:** assert `reset_n`=0 during AV_RD → all outputs at reset values immediately; after release, an Avalon read completes normally.
